// File: rtl/and2_stim_pkg.sv
// Shared definitions for the and2 stimulus/check sequencer: FSM encoding and
// the constant four-entry vector table (one input toggles per step).
package and2_stim_pkg;

  localparam int unsigned NUM_VEC = 4;
  localparam int unsigned VEC_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Applied inputs and expected and2 output per vector index
  localparam logic VEC_A   [NUM_VEC] = '{1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic VEC_B   [NUM_VEC] = '{1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic VEC_EXP [NUM_VEC] = '{1'b0, 1'b0, 1'b1, 1'b0};

endpackage

// File: rtl/and2_stim_seq_hold_timer.sv
// stim_hold_timer: per-vector hold counter for the and2 stimulus sequencer.
//  clk, rst_n    clock / async active-low reset
//  clr           force the counter to 0 at the next edge (wins over en)
//  en            count 0..HOLD_CYCLES-1, wrapping to 0
//  sample_strobe high in the enabled cycle where count == SAMPLE_OFFSET
//  hold_last     high in the enabled cycle where count == HOLD_CYCLES-1
module stim_hold_timer #(
  parameter int unsigned HOLD_CYCLES   = 10,
  parameter int unsigned SAMPLE_OFFSET = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic sample_strobe,
  output logic hold_last
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

  logic [CNT_W-1:0] hold_cnt;

  assign sample_strobe = en && (hold_cnt == CNT_W'(SAMPLE_OFFSET));
  assign hold_last     = en && (hold_cnt == CNT_W'(HOLD_CYCLES - 1));

  // Hold counter: clear has priority, wraps at the end of each vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (clr) begin
      hold_cnt <= '0;
    end else if (en) begin
      if (hold_last) hold_cnt <= '0;
      else           hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/and2_stim_seq.sv
// and2_stim_seq: clocked stimulus/check sequencer for an and2 gate.
// Drives four vectors (00,10,11,01) for HOLD_CYCLES clocks each, samples the
// gate output once per vector and counts mismatches (saturating).
//  clk, rst_n     clock / async active-low reset
//  start          1-cycle run request (ignored while busy)
//  dut_c          gate output under check, synchronous to clk
//  drv_a, drv_b   registered gate inputs
//  vec_idx        index of the vector currently applied
//  busy           run in progress (RUN or FINISH)
//  done           1-cycle pulse in the FINISH cycle
//  pass           last completed run had no mismatches
//  err_cnt        mismatches of current/last run
module and2_stim_seq
  import and2_stim_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 10,
  parameter int unsigned SAMPLE_OFFSET = 5,
  parameter int unsigned ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dut_c,
  output logic             drv_a,
  output logic             drv_b,
  output logic [1:0]       vec_idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
);

  // Parameter legality
  if (HOLD_CYCLES < 2) begin : g_bad_hold
    $fatal(1, "and2_stim_seq: HOLD_CYCLES must be >= 2");
  end
  if ((SAMPLE_OFFSET < 1) || (SAMPLE_OFFSET >= HOLD_CYCLES)) begin : g_bad_offset
    $fatal(1, "and2_stim_seq: SAMPLE_OFFSET must be in 1..HOLD_CYCLES-1");
  end

  state_e           state_q, state_d;
  logic             drv_a_d, drv_b_d;
  logic [1:0]       vec_idx_d, vec_nxt;
  logic             busy_d, done_d, pass_d;
  logic [ERR_W-1:0] err_cnt_d;
  logic             tmr_clr, tmr_en;
  logic             sample_strobe, hold_last;

  stim_hold_timer #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .SAMPLE_OFFSET (SAMPLE_OFFSET)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (tmr_clr),
    .en            (tmr_en),
    .sample_strobe (sample_strobe),
    .hold_last     (hold_last)
  );

  assign vec_nxt = vec_idx + 2'd1;

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    drv_a_d   = drv_a;
    drv_b_d   = drv_b;
    vec_idx_d = vec_idx;
    busy_d    = busy;
    done_d    = 1'b0;
    pass_d    = pass;
    err_cnt_d = err_cnt;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          busy_d    = 1'b1;
          vec_idx_d = 2'd0;
          drv_a_d   = VEC_A[0];
          drv_b_d   = VEC_B[0];
          err_cnt_d = '0;
          pass_d    = 1'b0;
          tmr_clr   = 1'b1;
        end
      end
      ST_RUN: begin
        tmr_en = 1'b1;
        if (sample_strobe && (dut_c != VEC_EXP[vec_idx]) && (err_cnt != '1)) begin
          err_cnt_d = err_cnt + ERR_W'(1);
        end
        if (hold_last) begin
          if (vec_idx != 2'd3) begin
            vec_idx_d = vec_nxt;
            drv_a_d   = VEC_A[vec_nxt];
            drv_b_d   = VEC_B[vec_nxt];
          end else begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end
        end
      end
      ST_FINISH: begin
        // Final sample has already been folded into err_cnt
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        pass_d  = (err_cnt == '0);
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      drv_a   <= 1'b0;
      drv_b   <= 1'b0;
      vec_idx <= 2'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
    end else begin
      state_q <= state_d;
      drv_a   <= drv_a_d;
      drv_b   <= drv_b_d;
      vec_idx <= vec_idx_d;
      busy    <= busy_d;
      done    <= done_d;
      pass    <= pass_d;
      err_cnt <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_and2_stim_seq.sv
// Directed bench for and2_stim_seq: golden, stuck-at-0, inverted (incl. a
// 2-bit saturating instance), ignored starts, back-to-back and mid-run reset.
// Cycle numbering inside a run: cycle 1 is the cycle start is high.
module tb_and2_stim_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;   // 0: and2, 1: stuck-at-0, 2: inverted
  logic       dut_c;
  logic       drv_a, drv_b, busy, done, pass;
  logic [1:0] vec_idx;
  logic [2:0] err_cnt;

  logic       s_c, s_a, s_b, s_busy, s_done, s_pass;
  logic [1:0] s_vec_idx;
  logic [1:0] s_err_cnt;

  int errors = 0;
  int checks = 0;

  logic [1:0] exp_ab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      2'd1:    dut_c = 1'b0;
      2'd2:    dut_c = ~(drv_a & drv_b);
      default: dut_c = drv_a & drv_b;
    endcase
  end

  assign s_c = ~(s_a & s_b);

  and2_stim_seq u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .dut_c   (dut_c),
    .drv_a   (drv_a),
    .drv_b   (drv_b),
    .vec_idx (vec_idx),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .err_cnt (err_cnt)
  );

  and2_stim_seq #(.ERR_W(2)) u_sat (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .dut_c   (s_c),
    .drv_a   (s_a),
    .drv_b   (s_b),
    .vec_idx (s_vec_idx),
    .busy    (s_busy),
    .done    (s_done),
    .pass    (s_pass),
    .err_cnt (s_err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One full run; returns in cycle 43 (IDLE, the cycle after done)
  task automatic run_seq(input string tag, input int exp_err, input bit exp_pass,
                         input bit inject, input bit chk_sat);
    int done_cnt;
    int done_cyc;
    int v;
    done_cnt = 0;
    done_cyc = 0;
    for (int c = 1; c <= 42; c++) begin
      start = (c == 1) || (inject && (c == 3 || c == 20 || c == 41));
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c + 1;
      end
      if (c + 1 == 2) begin
        chk({tag, " busy@2"}, 32'(busy), 32'd1);
        chk({tag, " err_clr@2"}, 32'(err_cnt), 32'd0);
        chk({tag, " pass_clr@2"}, 32'(pass), 32'd0);
        chk({tag, " drv@2"}, 32'({drv_a, drv_b}), 32'(exp_ab[0]));
      end
      if ((c + 1 >= 7) && (c + 1 <= 37) && (((c + 1 - 7) % 10) == 0)) begin
        v = (c + 1 - 7) / 10;
        chk($sformatf("%s drv v%0d", tag, v), 32'({drv_a, drv_b}), 32'(exp_ab[v]));
        chk($sformatf("%s vec_idx v%0d", tag, v), 32'(vec_idx), 32'(v));
      end
    end
    start = 1'b0;
    chk({tag, " done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, " done_cycle"}, 32'(done_cyc), 32'd42);
    chk({tag, " err_cnt"}, 32'(err_cnt), 32'(exp_err));
    chk({tag, " pass"}, 32'(pass), 32'(exp_pass));
    chk({tag, " busy_end"}, 32'(busy), 32'd0);
    chk({tag, " drv_hold"}, 32'({drv_a, drv_b}), 32'(exp_ab[3]));
    if (chk_sat) chk({tag, " sat_err"}, 32'(s_err_cnt), 32'd3);
  endtask

  initial begin
    int done_seen;

    // Reset state
    #12;
    chk("rst drv", 32'({drv_a, drv_b}), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst pass", 32'(pass), 32'd0);
    chk("rst err", 32'(err_cnt), 32'd0);
    chk("rst vec", 32'(vec_idx), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    mode = 2'd0; run_seq("golden", 0, 1'b1, 1'b0, 1'b0);
    mode = 2'd1; run_seq("stuck0", 1, 1'b0, 1'b0, 1'b0);
    mode = 2'd2; run_seq("invert", 4, 1'b0, 1'b0, 1'b1);
    mode = 2'd0; run_seq("ignore", 0, 1'b1, 1'b1, 1'b0);

    // Back-to-back: second start lands in the cycle right after done
    mode = 2'd2; run_seq("b2b_1", 4, 1'b0, 1'b0, 1'b0);
    mode = 2'd0; run_seq("b2b_2", 0, 1'b1, 1'b0, 1'b0);

    // Reset during vector 2 (cycles 22..31), asserted between edges
    mode = 2'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 2; c < 25; c++) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst vec", 32'(vec_idx), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst busy", 32'(busy), 32'd0);
    chk("mid_rst drv", 32'({drv_a, drv_b}), 32'd0);
    chk("mid_rst vec", 32'(vec_idx), 32'd0);
    chk("mid_rst err", 32'(err_cnt), 32'd0);
    done_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    chk("mid_rst no_done", 32'(done_seen), 32'd0);
    chk("mid_rst idle", 32'(busy), 32'd0);
    run_seq("after_rst", 0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
